// File: rtl/diot_gpio_pkg.sv
// Shared constants for the GPIO bank: register indices and reset values.
package diot_gpio_pkg;

  // Register index k; a slot's register k lives at address s + SLOTS*k.
  localparam int REG_OUT     = 0;
  localparam int REG_IN      = 1;
  localparam int REG_DIR     = 2;
  localparam int REG_STATUS  = 3;
  localparam int REG_MASK    = 4;
  localparam int REG_CLEAR   = 5;
  localparam int REG_RISE_EN = 6;
  localparam int REG_FALL_EN = 7;
  localparam int REG_COUNT   = 8;

  // Per-bit reset values, replicated to the register width where used.
  localparam logic RST_OUT_BIT     = 1'b0;
  localparam logic RST_DIR_BIT     = 1'b0;
  localparam logic RST_STATUS_BIT  = 1'b0;
  localparam logic RST_MASK_BIT    = 1'b0;
  localparam logic RST_RISE_EN_BIT = 1'b1;
  localparam logic RST_FALL_EN_BIT = 1'b0;
  localparam logic RST_SYNC_BIT    = 1'b0;

endpackage

// File: rtl/diot_gpio_slot.sv
// One GPIO slot: configuration registers, two-flop input synchronizer,
// previous-value flop for edge detection and sticky interrupt status.
module diot_gpio_slot
  import diot_gpio_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_out_i,
  input  logic              we_dir_i,
  input  logic              we_mask_i,
  input  logic              we_clear_i,
  input  logic              we_rise_i,
  input  logic              we_fall_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] pad_i,
  output logic [DATA_W-1:0] out_o,
  output logic [DATA_W-1:0] dir_o,
  output logic [DATA_W-1:0] in_o,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] mask_o,
  output logic [DATA_W-1:0] rise_en_o,
  output logic [DATA_W-1:0] fall_en_o
);

  logic [DATA_W-1:0] out_q, dir_q, mask_q, rise_q, fall_q;
  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] sync1_q, sync2_q, prev_q;
  logic [DATA_W-1:0] rise_ev, fall_ev, clr;

  // Software-writable configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= {DATA_W{RST_OUT_BIT}};
      dir_q  <= {DATA_W{RST_DIR_BIT}};
      mask_q <= {DATA_W{RST_MASK_BIT}};
      rise_q <= {DATA_W{RST_RISE_EN_BIT}};
      fall_q <= {DATA_W{RST_FALL_EN_BIT}};
    end else begin
      if (we_out_i)  out_q  <= wdata_i;
      if (we_dir_i)  dir_q  <= wdata_i;
      if (we_mask_i) mask_q <= wdata_i;
      if (we_rise_i) rise_q <= wdata_i;
      if (we_fall_i) fall_q <= wdata_i;
    end
  end

  // Two synchronizer stages plus one history stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= {DATA_W{RST_SYNC_BIT}};
      sync2_q <= {DATA_W{RST_SYNC_BIT}};
      prev_q  <= {DATA_W{RST_SYNC_BIT}};
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge events and sticky status next state; a new event beats a clear.
  always_comb begin
    rise_ev  = rise_q & sync2_q & ~prev_q;
    fall_ev  = fall_q & ~sync2_q & prev_q;
    clr      = we_clear_i ? wdata_i : '0;
    status_d = (status_q & ~clr) | rise_ev | fall_ev;
  end

  // Status register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) status_q <= {DATA_W{RST_STATUS_BIT}};
    else         status_q <= status_d;
  end

  assign out_o     = out_q;
  assign dir_o     = dir_q;
  assign in_o      = sync2_q;
  assign status_o  = status_q;
  assign mask_o    = mask_q;
  assign rise_en_o = rise_q;
  assign fall_en_o = fall_q;

endmodule

// File: rtl/diot_gpio_bank.sv
// GPIO bank top: address decode, registered read mux and irq reduction over
// SLOTS instances of diot_gpio_slot.
//
// Register bus: reg_we writes reg_wdata to reg_addr on the clock edge where it
// is high. reg_re is a one-cycle strobe; reg_rvalid/reg_rdata are high for
// exactly the following cycle (rdata is 0 otherwise). With reg_we and reg_re
// together the read returns the value as written. There is no back-pressure.
module diot_gpio_bank
  import diot_gpio_pkg::*;
#(
  parameter int SLOTS  = 1,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic [DATA_W-1:0]       reg_wdata,
  input  logic                    reg_we,
  input  logic                    reg_re,
  output logic [DATA_W-1:0]       reg_rdata,
  output logic                    reg_rvalid,
  input  logic [SLOTS*DATA_W-1:0] pad_i,
  output logic [SLOTS*DATA_W-1:0] pad_o,
  output logic [SLOTS*DATA_W-1:0] pad_oe,
  output logic                    irq
);

  localparam logic [ADDR_W-1:0] SLOTS_A = ADDR_W'(SLOTS);
  localparam logic [ADDR_W:0]   MAP_END = (ADDR_W + 1)'(REG_COUNT * SLOTS);

  logic [ADDR_W-1:0] slot_a, k_a;
  logic              in_range;

  logic [SLOTS-1:0] we_out, we_dir, we_mask, we_clr, we_rise, we_fall;

  logic [DATA_W-1:0] out_v    [SLOTS];
  logic [DATA_W-1:0] dir_v    [SLOTS];
  logic [DATA_W-1:0] in_v     [SLOTS];
  logic [DATA_W-1:0] status_v [SLOTS];
  logic [DATA_W-1:0] mask_v   [SLOTS];
  logic [DATA_W-1:0] rise_v   [SLOTS];
  logic [DATA_W-1:0] fall_v   [SLOTS];

  logic [DATA_W-1:0] rd_val, rdata_d, rdata_q;
  logic              rvalid_q, irq_d, irq_q;

  assign slot_a   = reg_addr % SLOTS_A;
  assign k_a      = reg_addr / SLOTS_A;
  assign in_range = {1'b0, reg_addr} < MAP_END;

  // Write decode to one-hot per-slot strobes; read-only registers get none.
  always_comb begin
    we_out  = '0;
    we_dir  = '0;
    we_mask = '0;
    we_clr  = '0;
    we_rise = '0;
    we_fall = '0;
    if (reg_we && in_range) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_a == ADDR_W'(s)) begin
          case (k_a)
            ADDR_W'(REG_OUT):     we_out[s]  = 1'b1;
            ADDR_W'(REG_DIR):     we_dir[s]  = 1'b1;
            ADDR_W'(REG_MASK):    we_mask[s] = 1'b1;
            ADDR_W'(REG_CLEAR):   we_clr[s]  = 1'b1;
            ADDR_W'(REG_RISE_EN): we_rise[s] = 1'b1;
            ADDR_W'(REG_FALL_EN): we_fall[s] = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    diot_gpio_slot #(.DATA_W(DATA_W)) u_slot (
      .clk_i      (sys_clk),
      .rst_ni     (sys_rst_n),
      .we_out_i   (we_out[g]),
      .we_dir_i   (we_dir[g]),
      .we_mask_i  (we_mask[g]),
      .we_clear_i (we_clr[g]),
      .we_rise_i  (we_rise[g]),
      .we_fall_i  (we_fall[g]),
      .wdata_i    (reg_wdata),
      .pad_i      (pad_i[g*DATA_W +: DATA_W]),
      .out_o      (out_v[g]),
      .dir_o      (dir_v[g]),
      .in_o       (in_v[g]),
      .status_o   (status_v[g]),
      .mask_o     (mask_v[g]),
      .rise_en_o  (rise_v[g]),
      .fall_en_o  (fall_v[g])
    );
    assign pad_o[g*DATA_W +: DATA_W]  = out_v[g];
    assign pad_oe[g*DATA_W +: DATA_W] = dir_v[g];
  end

  // Read mux; a simultaneous write to a writable register is forwarded.
  always_comb begin
    rd_val = '0;
    if (in_range) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_a == ADDR_W'(s)) begin
          case (k_a)
            ADDR_W'(REG_OUT):     rd_val = reg_we ? reg_wdata : out_v[s];
            ADDR_W'(REG_IN):      rd_val = in_v[s];
            ADDR_W'(REG_DIR):     rd_val = reg_we ? reg_wdata : dir_v[s];
            ADDR_W'(REG_STATUS):  rd_val = status_v[s];
            ADDR_W'(REG_MASK):    rd_val = reg_we ? reg_wdata : mask_v[s];
            ADDR_W'(REG_RISE_EN): rd_val = reg_we ? reg_wdata : rise_v[s];
            ADDR_W'(REG_FALL_EN): rd_val = reg_we ? reg_wdata : fall_v[s];
            default:              rd_val = '0;
          endcase
        end
      end
    end
    rdata_d = reg_re ? rd_val : '0;
  end

  // OR of masked pending status over all slots.
  always_comb begin
    irq_d = 1'b0;
    for (int s = 0; s < SLOTS; s++) irq_d = irq_d | (|(status_v[s] & mask_v[s]));
  end

  // Registered read response and interrupt output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= reg_re;
      irq_q    <= irq_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_diot_gpio_bank.sv
// Bench for diot_gpio_bank with SLOTS=2, DATA_W=16: directed steps followed by
// a random phase, all checked against a register-level reference model.
module tb_diot_gpio_bank;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        reg_rvalid;
  logic [31:0] pad_i;
  logic [31:0] pad_o;
  logic [31:0] pad_oe;
  logic        irq;

  int total = 0;
  int bad   = 0;

  diot_gpio_bank #(.SLOTS(2), .DATA_W(16), .ADDR_W(7)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .pad_i      (pad_i),
    .pad_o      (pad_o),
    .pad_oe     (pad_oe),
    .irq        (irq)
  );

  // Clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Reference model: register file per slot and a history of sampled pads.
  logic [15:0] m_out[2], m_dir[2], m_mask[2], m_rise[2], m_fall[2], m_status[2];
  logic [31:0] hist[3];
  logic [15:0] e_rdata;
  logic        e_rvalid, e_irq;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 16'h0; m_dir[i] = 16'h0; m_mask[i] = 16'h0;
      m_rise[i] = 16'hFFFF; m_fall[i] = 16'h0; m_status[i] = 16'h0;
    end
    for (int i = 0; i < 3; i++) hist[i] = 32'h0;
    e_rdata = 16'h0; e_rvalid = 1'b0; e_irq = 1'b0;
  endtask

  // One clock edge of the register map's behaviour, from the current inputs.
  task automatic model_edge();
    int a, s, k;
    bit mapped;
    logic [15:0] n_rd, cur, prv, ev, clr;
    logic n_irq;
    a = int'(reg_addr);
    mapped = (a < 16);
    s = a % 2;
    k = a / 2;
    n_rd = 16'h0;
    if (reg_re && mapped) begin
      case (k)
        0: n_rd = reg_we ? reg_wdata : m_out[s];
        1: n_rd = hist[1][s*16 +: 16];
        2: n_rd = reg_we ? reg_wdata : m_dir[s];
        3: n_rd = m_status[s];
        4: n_rd = reg_we ? reg_wdata : m_mask[s];
        6: n_rd = reg_we ? reg_wdata : m_rise[s];
        7: n_rd = reg_we ? reg_wdata : m_fall[s];
        default: n_rd = 16'h0;
      endcase
    end
    n_irq = 1'b0;
    for (int i = 0; i < 2; i++) n_irq = n_irq | (|(m_status[i] & m_mask[i]));
    for (int i = 0; i < 2; i++) begin
      cur = hist[1][i*16 +: 16];
      prv = hist[2][i*16 +: 16];
      ev  = (m_rise[i] & cur & ~prv) | (m_fall[i] & ~cur & prv);
      clr = (reg_we && mapped && k == 5 && s == i) ? reg_wdata : 16'h0;
      m_status[i] = (m_status[i] & ~clr) | ev;
    end
    if (reg_we && mapped) begin
      case (k)
        0: m_out[s]  = reg_wdata;
        2: m_dir[s]  = reg_wdata;
        4: m_mask[s] = reg_wdata;
        6: m_rise[s] = reg_wdata;
        7: m_fall[s] = reg_wdata;
        default: ;
      endcase
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = pad_i;
    e_rdata = n_rd;
    e_rvalid = reg_re;
    e_irq = n_irq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pad_o"},  pad_o,  {m_out[1], m_out[0]});
    chk({tag, ".pad_oe"}, pad_oe, {m_dir[1], m_dir[0]});
    chk({tag, ".irq"},    32'(irq), 32'(e_irq));
    chk({tag, ".rvalid"}, 32'(reg_rvalid), 32'(e_rvalid));
    chk({tag, ".rdata"},  32'(reg_rdata), 32'(e_rdata));
  endtask

  // Driver tasks: inputs change only at the falling edge.
  task automatic cycle(input string tag);
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle");
  endtask

  task automatic wr(input logic [6:0] addr, input logic [15:0] data);
    reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
    cycle("wr");
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [6:0] addr, input string tag);
    reg_re = 1'b1; reg_addr = addr;
    cycle(tag);
    reg_re = 1'b0;
    cycle({tag, "_after"});
  endtask

  initial begin
    int op;
    sys_rst_n = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_we = 1'b0; reg_re = 1'b0; pad_i = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs("reset");
    sys_rst_n = 1'b1;

    // Reset values of the enables.
    rd(7'd12, "rise_en_rst0");
    rd(7'd13, "rise_en_rst1");
    rd(7'd14, "fall_en_rst0");

    // Slot 1 output drive and read-back.
    wr(7'd1, 16'hAAAA);
    wr(7'd5, 16'hFFFF);
    rd(7'd1, "out1_read");

    // Input path regardless of DIR.
    wr(7'd4, 16'h0000);
    pad_i[15:0] = 16'h5555;
    idle(2);
    rd(7'd2, "in0_read");

    // Rising edge latency, irq, no falling event while FALL_EN=0.
    pad_i[15:0] = 16'h0000;
    idle(3);
    wr(7'd10, 16'hFFFF);
    wr(7'd8, 16'hFFFF);
    pad_i[0] = 1'b1;
    idle(4);
    rd(7'd6, "status_rise");
    pad_i[0] = 1'b0;
    idle(4);
    rd(7'd6, "status_nofall");

    // Falling event coincident with a clear: set wins.
    wr(7'd14, 16'h0001);
    pad_i[0] = 1'b1;
    idle(4);
    pad_i[0] = 1'b0;
    idle(2);
    wr(7'd10, 16'h0001);
    rd(7'd6, "status_set_wins");

    // Mask gating and unmapped address.
    wr(7'd8, 16'h0000);
    idle(2);
    wr(7'd8, 16'h0001);
    idle(2);
    wr(7'd20, 16'h1234);
    rd(7'd20, "unmapped_read");
    rd(7'd0, "out0_unchanged");
    rd(7'd11, "clear_read");

    // Read and write in the same cycle.
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = 7'd9; reg_wdata = 16'hC3C3;
    cycle("rw_same");
    reg_we = 1'b0; reg_re = 1'b0;
    cycle("rw_same_after");

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 3));
      reg_we = op[0];
      reg_re = op[1];
      reg_addr = 7'($urandom_range(0, 23));
      reg_wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) pad_i = pad_i ^ (32'h1 << $urandom_range(0, 31));
      cycle("rand");
    end
    reg_we = 1'b0; reg_re = 1'b0;

    // Asynchronous reset in the middle of a read.
    wr(7'd0, 16'h1234);
    wr(7'd4, 16'h00FF);
    reg_re = 1'b1; reg_addr = 7'd0;
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("rvalid_pre_rst", 32'(reg_rvalid), 32'h1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    reg_re = 1'b0;
    model_reset();
    check_outputs("async_rst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cycle("post_rst");
    rd(7'd12, "rise_en_post_rst");
    rd(7'd4, "dir_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diot_gpio_bank.md
DIOT_GPIO_BANK -- requirements
Module: diot_gpio_bank

Interface
REQ-001 SHALL have parameter SLOTS, default 1: number of GPIO slots, range 1..8.
REQ-002 SHALL have parameter DATA_W, default 16: pins per slot, equal to the register width.
REQ-003 SHALL have parameter ADDR_W, default 7: register address width; read/write is signalled separately, not by an address bit.
REQ-004 SHALL have one clock and an asynchronous active-low reset: sys_clk and sys_rst_n.
REQ-005 Ports (name, direction, width, meaning):
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- reg_addr  in  ADDR_W  register address.
- reg_wdata  in  DATA_W  write data.
- reg_we  in  1  write strobe, one cycle.
- reg_re  in  1  read strobe, one cycle.
- reg_rdata  out  DATA_W  read data.
- reg_rvalid  out  1  read data valid.
- pad_i  in  SLOTS*DATA_W  pad inputs; slot s occupies bits [s*DATA_W +: DATA_W].
- pad_o  out  SLOTS*DATA_W  pad output values.
- pad_oe  out  SLOTS*DATA_W  output enables; 1 = drive.
- irq  out  1  OR of all masked pending interrupts.

Function
REQ-006 Register index k occupies address s + SLOTS*k for slot s. k values: 0 OUT, 1 IN (read-only), 2 DIR, 3 STATUS (read-only), 4 MASK, 5 CLEAR (write-only), 6 RISE_EN, 7 FALL_EN.
REQ-007 Write behaviour:
- Takes effect on the sys_clk edge where reg_we=1.
- Writes to read-only registers, or to addresses >= 8*SLOTS, SHALL be ignored.
REQ-008 Read behaviour:
- reg_rdata and reg_rvalid SHALL assert exactly one cycle after reg_re and hold for one cycle.
- Reads of CLEAR or of unmapped addresses SHALL return 0.
REQ-009 reg_we and reg_re asserted in the same cycle: the write SHALL complete first, and the read SHALL return the value after the write.
REQ-010 pad_o SHALL equal OUT; pad_oe SHALL equal DIR. DIR bit 1 = output, 0 = input.
REQ-011 pad_i SHALL pass through a two-flop synchronizer. IN SHALL return the synchronized value whatever the DIR setting.
REQ-012 A third flop SHALL hold the previous synchronized value for edge detection.
- Rising event: prev=0, cur=1, and the RISE_EN bit is set.
- Falling event: prev=1, cur=0, and the FALL_EN bit is set.
REQ-013 STATUS bits:
- An event SHALL set its STATUS bit, which stays set (sticky) until cleared.
- Writing 1 to a CLEAR bit SHALL clear that STATUS bit; writing 0 has no effect.
- An event and a clear on the same bit in the same cycle: the set SHALL win.
REQ-014 irq SHALL be registered and equal OR over all slots of (STATUS & MASK). irq SHALL update one cycle after STATUS or MASK changes.
REQ-015 Latency from a pad transition to a STATUS bit set SHALL be 3 sys_clk cycles; irq SHALL follow one cycle later.
REQ-016 Changing MASK SHALL NOT alter STATUS; unmasked events SHALL still latch.

Reset
REQ-017 Asynchronous reset (sys_rst_n=0) SHALL set:
- OUT, DIR, STATUS, MASK, FALL_EN to 0.
- RISE_EN to all ones.
- All synchronizer and previous-value flops to 0.
- reg_rdata, reg_rvalid and irq to 0.
REQ-018 The first sampled high pad after reset release SHALL count as a rising edge. Software SHALL clear STATUS after configuration.
REQ-019 Reset asserted mid-read SHALL drop reg_rvalid immediately; no stale read is returned after release.

Structure
REQ-020 Package diot_gpio_pkg SHALL hold:
- register index constants REG_OUT..REG_FALL_EN (0..7);
- REG_COUNT = 8;
- the reset value constants.
REQ-021 Per-slot logic SHALL live in the sub-module diot_gpio_slot:
- registers, synchronizer, edge detect, status;
- generated SLOTS times.
REQ-022 The top level SHALL hold the address decode, the read mux and the irq reduction.

Verification
REQ-023 SLOTS=2, DATA_W=16. Write OUT of slot 1 (addr 1) = 0xAAAA and DIR (addr 5) = 0xFFFF -> pad_o[31:16]=0xAAAA and pad_oe[31:16]=0xFFFF; reading addr 1 returns 0xAAAA one cycle after reg_re.
REQ-024 DIR=0, pad_i[15:0]=0x5555 -> reading IN (addr 2) returns 0x5555 once at least 2 cycles have passed.
REQ-025 CLEAR=0xFFFF, MASK=0xFFFF, pad_i[0] 0->1 -> STATUS=0x0001 after 3 cycles; irq=1 on cycle 4; a further 1->0 leaves STATUS unchanged (FALL_EN=0).
REQ-026 FALL_EN=0x0001, then a falling edge coincident with a CLEAR=0x0001 write -> STATUS bit 0 stays 1.
REQ-027 MASK=0 with a pending STATUS -> irq=0; then MASK=0x0001 -> irq=1 one cycle later; a write to addr 20 (unmapped) changes nothing and reads back 0.
REQ-028 sys_rst_n pulsed low mid-operation -> every output and register returns to its reset value asynchronously.
